pio_edge_irq: RTL and testbench
===============================

# pio_edge_irq

Parametrised Avalon-MM general-purpose I/O port: per-bit direction, atomic set/clear of the output register, synchronised inputs, per-bit edge capture, and a maskable level interrupt to the Nios II. It is the general successor to the single-bit write-only PIO registers, such as the frame-buffer write-enable strobes, used in the system. One instance serves an arbitrary mix of control outputs and status/event inputs without software read-modify-write races.

## Interface
- WIDTH, 8: number of I/O bits, 1..32.
- OUT_RESET, 0: reset value of the output register (WIDTH bits).
- DIR_RESET, all ones: reset value of the direction register; 1 = output, 0 = input.
- EDGE_TYPE, 0: capture mode; 0 = rising, 1 = falling, 2 = any edge.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data; bits above WIDTH-1 are ignored.
- readdata  out  32  read data, zero-wait-state combinational; bits above WIDTH-1 read 0.
- in_port  in  WIDTH  asynchronous external inputs.
- out_port  out  WIDTH  output register contents.
- oe  out  WIDTH  direction register (drive enable per bit).
- irq  out  1  level interrupt request, active-high.

## Operation
- Register map (word addresses):
  - 0 DATA: read returns, per bit, the output register where dir=1 and the synchronised input where dir=0. Write loads the output register.
  - 1 DIR: read/write.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read returns captured edges. Writing 1 clears the corresponding bit; writing 0 leaves it unchanged.
  - 4 OUTSET: writing 1 sets the corresponding output bit. Reads return 0.
  - 5 OUTCLR: writing 1 clears the corresponding output bit. Reads return 0.
  - 6, 7: reserved. Writes are ignored; reads return 0.
- The output register updates regardless of DIR. DIR only gates oe and DATA readback.
- Synchroniser: SYNC_STAGES flops per bit, followed by one "prev" flop. Edge detect compares the last sync stage (s) with prev:
  - rise = s & ~prev
  - fall = ~s & prev
  - any = s ^ prev
- Edge capture sets a bit only when the edge is detected, DIR bit = 0, and the arm counter has expired.
- Simultaneous set and software clear of the same EDGECAP bit in one cycle: set wins (the event is not lost).
- irq = |(EDGECAP & IRQMASK), driven from registered state. Writing IRQMASK takes effect on the next cycle.
- Arm counter: after reset deasserts, edge capture is inhibited for SYNC_STAGES+1 cycles. This prevents spurious edges from the reset value of the synchroniser and prev flops.
- Reset values:
  - out_port = OUT_RESET, oe = DIR_RESET.
  - IRQMASK = 0, EDGECAP = 0, irq = 0.
  - Synchroniser and prev = 0.
  - Arm counter = 0 (inhibited).

## Timing
- Writes take effect at the clk edge where the write is sampled. out_port, oe, and mask are visible one cycle after the write cycle.
- Reads have zero wait states and zero latency. readdata reflects register state in the same cycle as the address.
- in_port change sampled at edge k:
  - visible in DATA read after edge k+SYNC_STAGES-1;
  - EDGECAP bit set at edge k+SYNC_STAGES;
  - irq high in the same cycle as the EDGECAP bit, if the bit is masked in.
- Input pulses shorter than one clk period may be missed. No requirement is placed on them.
- EDGECAP clear write at edge m: bit reads 0 and irq falls after edge m, unless a new edge is captured at m.
- Asserting reset_n low mid-operation clears all state immediately and asynchronously. The arm inhibit restarts on deassertion.

## Test plan
- Reset with WIDTH=8, OUT_RESET=0xA5, DIR_RESET=0x0F and in_port=0xFF held high -> out_port=0xA5, oe=0x0F, irq=0, EDGECAP reads 0x00 after 10 cycles (no spurious capture).
- Write DATA=0x3C, then OUTSET=0x01, then OUTCLR=0x04 -> out_port sequence 0x3C, 0x3D, 0x39; OUTSET/OUTCLR read 0.
- DIR=0x00, IRQMASK=0x10, EDGE_TYPE=0: raise in_port[4] at edge k -> EDGECAP=0x10 and irq=1 at edge k+2 (SYNC_STAGES=2). Write EDGECAP=0x10 -> irq=0 next cycle.
- Raise in_port[4] timed so its capture lands in the same cycle as an EDGECAP=0x10 clear write -> bit stays 1, irq stays 1.
- EDGE_TYPE=2, DIR=0x00: toggle in_port[0] high then low 5 cycles apart, clearing between -> two captures. Set DIR[0]=1 and toggle again -> no capture.
- Assert reset_n low for 1 cycle mid-transfer with EDGECAP=0xFF, IRQMASK=0xFF -> irq=0 immediately, all registers at reset values, capture re-armed after SYNC_STAGES+1 cycles.

Source files
------------

// File: rtl/pio_edge_irq.sv
// rtl/pio_edge_irq.sv - Avalon-MM GPIO with atomic set/clear, synchronised inputs,
// per-bit edge capture and a maskable level interrupt.
module pio_edge_irq #(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] OUT_RESET   = '0,
   parameter logic [WIDTH-1:0] DIR_RESET   = '1,
   parameter int unsigned      EDGE_TYPE   = 0,
   parameter int unsigned      SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] oe,
   output logic             irq
);

   localparam logic [2:0] ARM_CYCLES = 3'(SYNC_STAGES + 1);

   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] dir_q, dir_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   logic [2:0]       arm_q, arm_d;

   logic             wr_en;
   logic             armed;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] rd_val;
   logic             unused_wdata;

   assign unused_wdata = ^writedata;

   always_comb begin
      wr_en  = chipselect & ~write_n;
      wd     = writedata[WIDTH-1:0];
      out_d  = out_q;
      dir_d  = dir_q;
      mask_d = mask_q;
      clr    = '0;
      if (wr_en) begin
         case (address)
            3'd0:    out_d  = wd;
            3'd1:    dir_d  = wd;
            3'd2:    mask_d = wd;
            3'd3:    clr    = wd;
            3'd4:    out_d  = out_q | wd;
            3'd5:    out_d  = out_q & ~wd;
            default: ;
         endcase
      end

      sync_d[0] = in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      s      = sync_q[SYNC_STAGES-1];
      prev_d = s;

      case (EDGE_TYPE)
         0:       edge_det = s & ~prev_q;
         1:       edge_det = ~s & prev_q;
         default: edge_det = s ^ prev_q;
      endcase

      // Capture stays off until the reset zeros have flushed through sync and prev.
      armed = (arm_q == ARM_CYCLES);
      arm_d = armed ? arm_q : arm_q + 3'd1;

      // A new edge overrides a same-cycle software clear so no event is lost.
      cap_d = (cap_q & ~clr) | (armed ? (edge_det & ~dir_q) : '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q  <= OUT_RESET;
         dir_q  <= DIR_RESET;
         mask_q <= '0;
         cap_q  <= '0;
         prev_q <= '0;
         sync_q <= '0;
         arm_q  <= '0;
      end else begin
         out_q  <= out_d;
         dir_q  <= dir_d;
         mask_q <= mask_d;
         cap_q  <= cap_d;
         prev_q <= prev_d;
         sync_q <= sync_d;
         arm_q  <= arm_d;
      end
   end

   always_comb begin
      rd_val = '0;
      case (address)
         3'd0:    rd_val = (out_q & dir_q) | (s & ~dir_q);
         3'd1:    rd_val = dir_q;
         3'd2:    rd_val = mask_q;
         3'd3:    rd_val = cap_q;
         default: rd_val = '0;
      endcase
   end

   assign readdata = 32'(rd_val);
   assign out_port = out_q;
   assign oe       = dir_q;
   assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_edge_irq.sv
// tb/tb_pio_edge_irq.sv - directed bench for pio_edge_irq: a rising-edge instance
// plus an any-edge instance sharing the bus and inputs.
module tb_pio_edge_irq;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata, readdata2;
   logic [7:0]  in_port;
   logic [7:0]  out_port, out_port2;
   logic [7:0]  oe, oe2;
   logic        irq, irq2;

   int checks = 0;
   int errors = 0;

   pio_edge_irq #(.WIDTH(8), .OUT_RESET(8'hA5), .DIR_RESET(8'h0F),
                  .EDGE_TYPE(0), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq));

   pio_edge_irq #(.WIDTH(8), .OUT_RESET(8'hA5), .DIR_RESET(8'h0F),
                  .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_any (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata2),
      .in_port(in_port), .out_port(out_port2), .oe(oe2), .irq(irq2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        wr;
      logic [2:0]  a;
      logic [31:0] d;
      logic [7:0]  eo;
      logic [7:0]  eoe;
      logic [31:0] er;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d1, output logic [31:0] d2);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      #1;
      d1 = readdata;
      d2 = readdata2;
      chipselect = 1'b0;
   endtask

   initial begin
      logic [31:0] r1, r2;

      vecs[0]  = '{1'b1, 3'd0, 32'h1234_563C, 8'h3C, 8'h0F, 32'h0};
      vecs[1]  = '{1'b1, 3'd4, 32'h0000_0001, 8'h3D, 8'h0F, 32'h0};
      vecs[2]  = '{1'b1, 3'd5, 32'h0000_0004, 8'h39, 8'h0F, 32'h0};
      vecs[3]  = '{1'b0, 3'd4, 32'h0,         8'h39, 8'h0F, 32'h0};
      vecs[4]  = '{1'b0, 3'd5, 32'h0,         8'h39, 8'h0F, 32'h0};
      vecs[5]  = '{1'b0, 3'd0, 32'h0,         8'h39, 8'h0F, 32'hF9};
      vecs[6]  = '{1'b1, 3'd6, 32'hFFFF_FFFF, 8'h39, 8'h0F, 32'h0};
      vecs[7]  = '{1'b1, 3'd7, 32'hFFFF_FFFF, 8'h39, 8'h0F, 32'h0};
      vecs[8]  = '{1'b0, 3'd6, 32'h0,         8'h39, 8'h0F, 32'h0};
      vecs[9]  = '{1'b0, 3'd7, 32'h0,         8'h39, 8'h0F, 32'h0};
      vecs[10] = '{1'b1, 3'd1, 32'hFFFF_FF00, 8'h39, 8'h00, 32'h0};
      vecs[11] = '{1'b0, 3'd1, 32'h0,         8'h39, 8'h00, 32'h0};
      vecs[12] = '{1'b0, 3'd0, 32'h0,         8'h39, 8'h00, 32'hFF};
      vecs[13] = '{1'b1, 3'd2, 32'h0000_0010, 8'h39, 8'h00, 32'h0};
      vecs[14] = '{1'b0, 3'd2, 32'h0,         8'h39, 8'h00, 32'h10};
      vecs[15] = '{1'b0, 3'd3, 32'h0,         8'h39, 8'h00, 32'h0};

      reset_n    = 1'b0;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
      in_port    = 8'hFF;
      repeat (3) @(negedge clk);
      chk("rst_out", 32'(out_port), 32'hA5);
      chk("rst_oe", 32'(oe), 32'h0F);
      chk("rst_irq", 32'(irq), 32'h0);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      rd(3'd3, r1, r2);
      chk("rst_nocap", r1, 32'h0);
      chk("rst_nocap_any", r2, 32'h0);
      chk("rst_irq_late", 32'(irq), 32'h0);

      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         if (vecs[i].wr) begin
            wr(vecs[i].a, vecs[i].d);
         end else begin
            rd(vecs[i].a, r1, r2);
            chk($sformatf("vec%0d_rd", i), r1, vecs[i].er);
            @(negedge clk);
         end
         chk($sformatf("vec%0d_out", i), 32'(out_port), 32'(vecs[i].eo));
         chk($sformatf("vec%0d_oe", i), 32'(oe), 32'(vecs[i].eoe));
      end

      // Falling edges: ignored by the rising instance, captured by the any-edge one.
      in_port = 8'h00;
      repeat (5) @(negedge clk);
      rd(3'd3, r1, r2);
      chk("fall_rise_mode", r1, 32'h00);
      chk("fall_any_mode", r2, 32'hFF);
      @(negedge clk);
      wr(3'd3, 32'hFF);
      rd(3'd3, r1, r2);
      chk("clr_all_any", r2, 32'h00);
      @(negedge clk);

      // Rising edge latency: sampled at edge k, captured at k+2.
      in_port = 8'h10;
      @(negedge clk);
      @(negedge clk);
      rd(3'd3, r1, r2);
      chk("lat_k1_cap", r1, 32'h00);
      chk("lat_k1_irq", 32'(irq), 32'h0);
      @(negedge clk);
      rd(3'd3, r1, r2);
      chk("lat_k2_cap", r1, 32'h10);
      chk("lat_k2_irq", 32'(irq), 32'h1);
      @(negedge clk);
      wr(3'd3, 32'h10);
      chk("clr_irq", 32'(irq), 32'h0);
      rd(3'd3, r1, r2);
      chk("clr_cap", r1, 32'h00);
      @(negedge clk);

      // Capture landing on the same edge as a clear write.
      in_port = 8'h00;
      repeat (4) @(negedge clk);
      wr(3'd3, 32'hFF);
      in_port = 8'h10;
      @(negedge clk);
      @(negedge clk);
      address    = 3'd3;
      writedata  = 32'h10;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      rd(3'd3, r1, r2);
      chk("collide_cap", r1, 32'h10);
      chk("collide_irq", 32'(irq), 32'h1);
      @(negedge clk);
      chk("collide_irq_hold", 32'(irq), 32'h1);
      wr(3'd3, 32'hFF);
      chk("collide_clr_irq", 32'(irq), 32'h0);

      // Any-edge mode on bit 0, then masked off by DIR.
      in_port = 8'h11;
      repeat (5) @(negedge clk);
      rd(3'd3, r1, r2);
      chk("any_rise", r2, 32'h01);
      @(negedge clk);
      wr(3'd3, 32'hFF);
      rd(3'd3, r1, r2);
      chk("any_rise_clr", r2, 32'h00);
      @(negedge clk);
      in_port = 8'h10;
      repeat (5) @(negedge clk);
      rd(3'd3, r1, r2);
      chk("any_fall", r2, 32'h01);
      chk("rise_ignores_fall", r1, 32'h00);
      @(negedge clk);
      wr(3'd3, 32'hFF);
      wr(3'd1, 32'h01);
      in_port = 8'h11;
      repeat (5) @(negedge clk);
      rd(3'd3, r1, r2);
      chk("dir_out_rise_any", r2, 32'h00);
      chk("dir_out_rise", r1, 32'h00);
      @(negedge clk);
      in_port = 8'h10;
      repeat (5) @(negedge clk);
      rd(3'd3, r1, r2);
      chk("dir_out_fall_any", r2, 32'h00);
      @(negedge clk);

      // Fill EDGECAP and IRQMASK, then reset mid-write.
      wr(3'd1, 32'h00);
      wr(3'd2, 32'hFF);
      in_port = 8'h00;
      repeat (5) @(negedge clk);
      wr(3'd3, 32'hFF);
      in_port = 8'hFF;
      repeat (5) @(negedge clk);
      rd(3'd3, r1, r2);
      chk("pre_rst_cap", r1, 32'hFF);
      chk("pre_rst_irq", 32'(irq), 32'h1);
      @(negedge clk);
      address    = 3'd2;
      writedata  = 32'h0;
      chipselect = 1'b1;
      write_n    = 1'b0;
      in_port    = 8'h00;
      reset_n    = 1'b0;
      #1;
      chk("async_irq", 32'(irq), 32'h0);
      chk("async_irq_any", 32'(irq2), 32'h0);
      chk("async_out", 32'(out_port), 32'hA5);
      chk("async_oe", 32'(oe), 32'h0F);
      @(negedge clk);
      reset_n    = 1'b1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      @(negedge clk);
      in_port = 8'h80;
      @(negedge clk);
      @(negedge clk);
      rd(3'd3, r1, r2);
      chk("rearm_e3", r1, 32'h00);
      @(negedge clk);
      rd(3'd3, r1, r2);
      chk("rearm_e4", r1, 32'h80);
      rd(3'd2, r1, r2);
      chk("rst2_mask", r1, 32'h00);
      rd(3'd1, r1, r2);
      chk("rst2_dir", r1, 32'h0F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
